// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder. Accepts one
//               load/store request at a time, waits WAIT_STATES cycles, then
//               performs the array access and presents a held response
//               until the initiator takes it.
// Ports       : clk, rst_n (async, active-low)
//               req_valid/req_ready/req_we/req_be/req_addr/req_wdata - request
//               rsp_valid/rsp_ready/rsp_rdata/rsp_err               - response
//               busy - high whenever the FSM is outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [29:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned c_IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [3:0]  r_be;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_busy;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    // With zero wait states the array is accessed on the accept edge itself,
    // before the capture registers hold the request, so the access operands
    // come straight from the request port in IDLE.
    logic        w_from_port;
    logic        w_acc_we;
    logic [3:0]  w_acc_be;
    logic [29:0] w_acc_addr;
    logic [31:0] w_acc_wdata;
    logic        w_acc_in_range;
    logic        w_enter_resp;
    logic        w_commit;
    logic [31:0] w_rd_word;
    logic [31:0] w_rsp_rdata;

    assign w_from_port    = (r_state == ST_IDLE);
    assign w_acc_we       = w_from_port ? req_we    : r_we;
    assign w_acc_be       = w_from_port ? req_be    : r_be;
    assign w_acc_addr     = w_from_port ? req_addr  : r_addr;
    assign w_acc_wdata    = w_from_port ? req_wdata : r_wdata;
    assign w_acc_in_range = ({2'b00, w_acc_addr} < DEPTH_WORDS);

    assign w_enter_resp = ((r_state == ST_IDLE) && req_valid && (WAIT_STATES == 0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd0));

    // rst_n gating keeps a request sitting on the port during reset from
    // being written when WAIT_STATES is zero.
    assign w_commit    = rst_n && w_enter_resp && w_acc_we && w_acc_in_range;
    assign w_rsp_rdata = (!w_acc_we && w_acc_in_range) ? w_rd_word : 32'h0;

    // Storage is split into four byte lanes so partial stores need no
    // read-modify-write; lanes are never reset.
    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (w_commit && w_acc_be[i]) begin
                    r_mem[w_acc_addr[c_IDX_W-1:0]] <= w_acc_wdata[8*i +: 8];
                end
            end

            assign w_rd_word[8*i +: 8] = r_mem[w_acc_addr[c_IDX_W-1:0]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_be        <= 4'd0;
            r_addr      <= 30'd0;
            r_wdata     <= 32'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_be        <= req_be;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rsp_rdata;
                            r_rsp_err   <= !w_acc_in_range;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp_rdata;
                        r_rsp_err   <= !w_acc_in_range;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Response fields stay untouched here so they hold until
                    // the handshake edge.
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. Three instances with
//               different depth / wait-state settings are driven with
//               directed and random transactions and compared to a
//               word-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
    logic [3:0]  req_be    [3];
    logic [29:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [31:0] rsp_rdata [3];

    int  total = 0;
    int  bad   = 0;
    time acc_t [3];
    logic [31:0] mdl [longint];

    function automatic int ws(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic int dep(input int k);
        return (k == 0) ? 1024 : ((k == 1) ? 64 : 16);
    endfunction

    function automatic longint key(input int k, input logic [29:0] a);
        return (longint'(k) << 32) | longint'(a);
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            dmem_responder #(
                .DEPTH_WORDS((g == 0) ? 1024 : ((g == 1) ? 64 : 16)),
                .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n[g]),
                .req_valid(req_valid[g]),
                .req_ready(req_ready[g]),
                .req_we   (req_we[g]),
                .req_be   (req_be[g]),
                .req_addr (req_addr[g]),
                .req_wdata(req_wdata[g]),
                .rsp_valid(rsp_valid[g]),
                .rsp_ready(rsp_ready[g]),
                .rsp_rdata(rsp_rdata[g]),
                .rsp_err  (rsp_err[g]),
                .busy     (busy[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble(input int k);
        req_we[k]    = 1'($urandom);
        req_be[k]    = 4'($urandom);
        req_addr[k]  = 30'($urandom);
        req_wdata[k] = $urandom;
    endtask

    // One complete transaction; called #1 after a rising edge.
    task automatic txn(input int k, input bit we, input logic [3:0] be,
                       input logic [29:0] addr, input logic [31:0] wdata, input int stall);
        bit          err;
        bit          known;
        logic [31:0] exp_d;
        logic [31:0] cur;
        err   = (int'(addr) >= dep(k));
        known = 1'b1;
        exp_d = 32'h0;
        if (!we && !err) begin
            if (mdl.exists(key(k, addr))) exp_d = mdl[key(k, addr)];
            else known = 1'b0;
        end
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_be[k]    = be;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        rsp_ready[k] = (stall == 0);
        chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        acc_t[k] = $time;
        #1;
        req_valid[k] = 1'b0;
        scramble(k);
        chk("busy_after_accept", 32'(busy[k]), 32'd1);
        chk("req_ready_after_accept", 32'(req_ready[k]), 32'd0);
        for (int i = 0; i <= ws(k); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            chk("rsp_valid_latency", 32'(rsp_valid[k]), 32'(i == ws(k)));
        end
        chk("rsp_err", 32'(rsp_err[k]), 32'(err));
        if (known) chk("rsp_rdata", rsp_rdata[k], exp_d);
        for (int s = 0; s < stall; s++) begin
            if (s == 0) req_valid[k] = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid[k]), 32'd1);
            chk("hold_busy", 32'(busy[k]), 32'd1);
            chk("hold_req_ready", 32'(req_ready[k]), 32'd0);
            chk("hold_err", 32'(rsp_err[k]), 32'(err));
            if (known) chk("hold_rdata", rsp_rdata[k], exp_d);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        chk("exit_valid", 32'(rsp_valid[k]), 32'd0);
        chk("exit_busy", 32'(busy[k]), 32'd0);
        chk("exit_req_ready", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b0;
        if (we && !err && (mdl.exists(key(k, addr)) || be == 4'hF)) begin
            cur = mdl.exists(key(k, addr)) ? mdl[key(k, addr)] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) cur[8*b +: 8] = wdata[8*b +: 8];
            end
            mdl[key(k, addr)] = cur;
        end
    endtask

    initial begin
        logic [29:0] pool [10];
        time t0;
        rst_n     = 3'b000;
        req_valid = 3'b000;
        rsp_ready = 3'b000;
        for (int k = 0; k < 3; k++) begin
            req_we[k] = 1'b0; req_be[k] = 4'h0; req_addr[k] = 30'h0; req_wdata[k] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_req_ready", 32'(req_ready[k]), 32'd1);
            chk("reset_busy", 32'(busy[k]), 32'd0);
            chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("reset_rdata", rsp_rdata[k], 32'h0);
            chk("reset_err", 32'(rsp_err[k]), 32'd0);
        end
        rst_n = 3'b111;

        // Basic store/load, byte lanes, empty byte enable.
        txn(0, 1'b1, 4'hF, 30'd5, 32'hDEADBEEF, 0);
        txn(0, 1'b0, 4'h0, 30'd5, 32'h0, 0);
        txn(0, 1'b1, 4'h4, 30'd5, 32'h00AA0000, 0);
        txn(0, 1'b0, 4'hF, 30'd5, 32'h0, 1);
        txn(0, 1'b1, 4'h0, 30'd5, 32'h55555555, 0);
        txn(0, 1'b0, 4'h3, 30'd5, 32'h0, 0);
        // Out of range: error, and the aliased word 0 stays untouched.
        txn(0, 1'b1, 4'hF, 30'd0, 32'h11111111, 0);
        txn(0, 1'b0, 4'hF, 30'd1024, 32'h0, 0);
        txn(0, 1'b1, 4'hF, 30'd1024, 32'hCAFEF00D, 0);
        txn(0, 1'b0, 4'hF, 30'd0, 32'h0, 0);
        // Back-pressure for five cycles with an ignored request pulse.
        txn(0, 1'b0, 4'hF, 30'd5, 32'h0, 5);

        // Reset while a response is pending drops it at once.
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_be[0] = 4'hF; req_addr[0] = 30'd5;
        rsp_ready[0] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_reset_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("resp_reset_valid", 32'(rsp_valid[0]), 32'd0);
        chk("resp_reset_rdata", rsp_rdata[0], 32'h0);
        chk("resp_reset_busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        txn(0, 1'b0, 4'hF, 30'd5, 32'h0, 0);

        // Reset during WAIT aborts a store.
        txn(1, 1'b1, 4'hF, 30'd7, 32'hA5A5A5A5, 0);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_be[1] = 4'hF;
        req_addr[1] = 30'd7; req_wdata[1] = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wait_busy", 32'(busy[1]), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        chk("wait_reset_busy", 32'(busy[1]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("wait_reset_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        rst_n[1] = 1'b1;
        txn(1, 1'b0, 4'hF, 30'd7, 32'h0, 0);

        // Zero wait states: back-to-back accepts every two cycles.
        txn(2, 1'b1, 4'hF, 30'd3, 32'h0BADF00D, 0);
        t0 = acc_t[2];
        txn(2, 1'b0, 4'hF, 30'd3, 32'h0, 0);
        chk("b2b_gap1", 32'(acc_t[2] - t0), 32'd20);
        t0 = acc_t[2];
        txn(2, 1'b1, 4'h9, 30'd3, 32'hFF0000EE, 0);
        chk("b2b_gap2", 32'(acc_t[2] - t0), 32'd20);
        t0 = acc_t[2];
        txn(2, 1'b0, 4'hF, 30'd3, 32'h0, 0);
        chk("b2b_gap3", 32'(acc_t[2] - t0), 32'd20);

        // Random traffic against the word model.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 7; i++) pool[i] = 30'(i);
            pool[7] = 30'(dep(k) - 1);
            pool[8] = 30'(dep(k));
            pool[9] = 30'h3FFFFFFF;
            for (int i = 0; i < 8; i++) txn(k, 1'b1, 4'hF, pool[i], $urandom, 0);
            for (int n = 0; n < 30; n++) begin
                txn(k, 1'($urandom), 4'($urandom), pool[$urandom_range(0, 9)],
                    $urandom, int'($urandom_range(0, 2)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 1024; number of 32-bit words in the array; power of two, 4..65536.
REQ-002 Parameter: WAIT_STATES, default 1; extra cycles between request accept and response; range 0..15.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 Port: req_valid  input  1  initiator presents a request.
REQ-006 Port: req_ready  output  1  responder can accept a request this cycle.
REQ-007 Port: req_we  input  1  1 = store, 0 = load.
REQ-008 Port: req_be  input  4  byte enables, bit i selects bits [8i+7:8i].
REQ-009 Port: req_addr  input  30  word address, byte address bits [31:2].
REQ-010 Port: req_wdata  input  32  store data, already lane-aligned.
REQ-011 Port: rsp_valid  output  1  response available.
REQ-012 Port: rsp_ready  input  1  initiator accepts the response.
REQ-013 Port: rsp_rdata  output  32  full loaded word (no extension); 0 for stores and errors.
REQ-014 Port: rsp_err  output  1  request address >= DEPTH_WORDS.
REQ-015 Port: busy  output  1  high whenever state != IDLE; drives the hazard-unit stall.

Function
REQ-016 FSM states: IDLE, WAIT, RESP; encoding is free.
REQ-017 req_ready SHALL be 1 exactly in IDLE; rsp_valid SHALL be 1 exactly in RESP.
REQ-018 Accept occurs on a rising edge with req_valid=1 in IDLE; addr, be, wdata and we are captured in internal registers.
REQ-019 Request inputs outside the accept edge are ignored; the initiator may change them freely after accept.
REQ-020 On accept: WAIT_STATES=0 -> RESP; otherwise -> WAIT with a 4-bit counter loaded with WAIT_STATES-1.
REQ-021 WAIT decrements the counter each cycle; when the counter = 0, the next edge moves to RESP.
REQ-022 Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accept edge.
REQ-023 Array access (store commit or load capture) occurs on the edge entering RESP, using only the captured registers.
REQ-024 Store: each byte with captured be[i]=1 is written; other bytes are unchanged; be=0000 writes nothing but still responds.
REQ-025 Load: rsp_rdata = the whole addressed word, independent of be.
REQ-026 Out of range (captured addr >= DEPTH_WORDS): no array write, rsp_rdata=0, rsp_err=1; in range: rsp_err=0.
REQ-027 rsp_rdata and rsp_err SHALL hold stable from RESP entry until the rsp_valid & rsp_ready edge.
REQ-028 RESP -> IDLE on the edge where rsp_ready=1; otherwise stay in RESP indefinitely.
REQ-029 There is no pipelining: a new request is never accepted in WAIT or RESP, including the RESP exit cycle.
REQ-030 Load after a store to the same word returns the post-store value.
REQ-031 Array width 32 bits, index = captured addr[log2(DEPTH_WORDS)-1:0]; upper bits are used only for the range check.

Reset
REQ-032 While rst_n=0: state=IDLE, counter=0, capture registers=0, rsp_rdata=0, rsp_err=0, rsp_valid=0, busy=0, req_ready=1.
REQ-033 Reset in WAIT aborts the transaction: a pending store SHALL NOT be committed and no response is issued.
REQ-034 Reset in RESP drops the response; rsp_valid=0 in the same cycle rst_n falls.
REQ-035 Array contents are not reset and are preserved across reset.
REQ-036 The first accept is possible on the first rising edge with rst_n=1.

Verification
REQ-037 WAIT_STATES=1: store addr=5, be=1111, wdata=0xDEADBEEF, rsp_ready=1 -> rsp_valid on cycle 2 after accept, rdata=0, err=0; load addr=5 -> rdata=0xDEADBEEF.
REQ-038 Byte store: word 5 = 0xDEADBEEF, store be=0100, wdata=0x00AA0000 -> load returns 0xDEAABEEF; be=0000 store -> word unchanged, response still issued.
REQ-039 Out-of-range: DEPTH_WORDS=1024, load addr=1024 -> rsp_err=1, rdata=0; store to 1024 leaves word 0 unchanged.
REQ-040 Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid, rdata and busy held, req_ready=0, a req_valid pulse is ignored; rsp_ready=1 -> IDLE the next cycle.
REQ-041 Reset mid-WAIT (WAIT_STATES=3): store 0x12345678 to addr 7, rst_n low on cycle 2 -> no response; a later load of addr 7 returns the old value.
REQ-042 WAIT_STATES=0: accept followed by RESP on the next cycle; back-to-back load/store/load with rsp_ready=1 -> one accept every 2 cycles.
